id_ex_stage: RTL and testbench

- ID/EX pipeline register that sits directly downstream of the register file and the decoder.
- Each cycle it captures readData1/readData2, immediate, PC and the decoded control bundle.
- Detects load-use hazards and stalls IF/ID while inserting a bubble; handles branch flush and downstream hold.
- Pre-computes registered forwarding selects that the EX stage uses.

---
 rtl/id_ex_stage_pkg.sv | 48 ++++
 rtl/id_ex_stage_if.sv | 56 +++++
 rtl/id_ex_stage_hazard_unit.sv | 47 ++++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the ID/EX boundary: decoded control bundle,
// forwarding select encoding and the forwarding-priority helper.
package rv_pipe_pkg;

  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic [3:0] aluOp;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  // The instruction now in EX reaches MEM next cycle, so it beats the one now in MEM.
  function automatic fwd_sel_t fwdSelect(
    input logic                 useRs,
    input logic [REG_IDX_W-1:0] rs,
    input logic                 exValid,
    input logic                 exRegWrite,
    input logic [REG_IDX_W-1:0] exRd,
    input logic                 exmemRegWrite,
    input logic [REG_IDX_W-1:0] exmemRd
  );
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (useRs && rs != '0) begin
      if (exValid && exRegWrite && exRd == rs) begin
        sel = FWD_MEM;
      end else if (exmemRegWrite && exmemRd == rs) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decoder/regfile inputs, EX-side control and registered ID/EX outputs.
// master drives the ID side and observes EX; slave is the pipeline register.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import rv_pipe_pkg::*;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_useRs1;
  logic            id_useRs2;
  logic [XLEN-1:0] id_imm;
  ctrl_t           id_ctrl;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic [4:0]      exmem_rd;
  logic            exmem_regWrite;
  logic            ex_flush;
  logic            ex_hold;

  logic             ifid_stall;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_imm;
  ctrl_t            ex_ctrl;
  logic [XLEN-1:0]  ex_rs1Data;
  logic [XLEN-1:0]  ex_rs2Data;
  fwd_sel_t         ex_fwdA;
  fwd_sel_t         ex_fwdB;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_useRs1, id_useRs2,
           id_imm, id_ctrl, readData1, readData2, exmem_rd, exmem_regWrite,
           ex_flush, ex_hold,
    input  ifid_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
           ex_rs1Data, ex_rs2Data, ex_fwdA, ex_fwdB, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_useRs1, id_useRs2,
           id_imm, id_ctrl, readData1, readData2, exmem_rd, exmem_regWrite,
           ex_flush, ex_hold,
    output ifid_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
           ex_rs1Data, ex_rs2Data, ex_fwdA, ex_fwdB, stall_count, flush_count
  );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use detection and forwarding select for both source operands
// of the instruction sitting in ID, judged against the EX and MEM occupants.
module hazard_unit
  import rv_pipe_pkg::*;
(
  input  logic     idValid,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic     idUseRs1,
  input  logic     idUseRs2,
  input  logic     exValid,
  input  ctrl_t    exCtrl,
  input  logic [4:0] exRd,
  input  logic [4:0] exmemRd,
  input  logic     exmemRegWrite,
  output logic     loadUse,
  output fwd_sel_t fwdA,
  output fwd_sel_t fwdB
);

  logic [1:0][4:0] srcRs;
  logic [1:0]      srcUse;
  logic [1:0]      srcLoadHit;
  logic [1:0][1:0] srcFwd;

  assign srcRs[0]  = idRs1;
  assign srcRs[1]  = idRs2;
  assign srcUse[0] = idUseRs1;
  assign srcUse[1] = idUseRs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // exRd != 0 is checked once below, which also keeps x0 from ever matching.
      assign srcLoadHit[gi] = srcUse[gi] && (srcRs[gi] == exRd);
      assign srcFwd[gi]     = fwdSelect(srcUse[gi], srcRs[gi], exValid,
                                        exCtrl.regWrite, exRd,
                                        exmemRegWrite, exmemRd);
    end
  endgenerate

  assign loadUse = idValid && exValid && exCtrl.memRead && (exRd != 5'd0)
                   && (|srcLoadHit);
  assign fwdA    = fwd_sel_t'(srcFwd[0]);
  assign fwdB    = fwd_sel_t'(srcFwd[1]);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush (remembered
// across a downstream hold), registered forwarding selects and saturating perf counters.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  logic     hazard;
  fwd_sel_t fwdA;
  fwd_sel_t fwdB;
  logic     flushApply;
  logic     stallEvent;

  logic             exValid_reg;
  logic [XLEN-1:0]  exPc_reg;
  logic [4:0]       exRs1_reg;
  logic [4:0]       exRs2_reg;
  logic [4:0]       exRd_reg;
  logic [XLEN-1:0]  exImm_reg;
  ctrl_t            exCtrl_reg;
  logic [XLEN-1:0]  exRs1Data_reg;
  logic [XLEN-1:0]  exRs2Data_reg;
  fwd_sel_t         exFwdA_reg;
  fwd_sel_t         exFwdB_reg;
  logic             pendingFlush_reg;
  logic [CNT_W-1:0] stallCount_reg;
  logic [CNT_W-1:0] flushCount_reg;

  hazard_unit u_hazard (
    .idValid       (bus.id_valid),
    .idRs1         (bus.id_rs1),
    .idRs2         (bus.id_rs2),
    .idUseRs1      (bus.id_useRs1),
    .idUseRs2      (bus.id_useRs2),
    .exValid       (exValid_reg),
    .exCtrl        (exCtrl_reg),
    .exRd          (exRd_reg),
    .exmemRd       (bus.exmem_rd),
    .exmemRegWrite (bus.exmem_regWrite),
    .loadUse       (hazard),
    .fwdA          (fwdA),
    .fwdB          (fwdB)
  );

  // A flush seen during a hold is deferred and applied on the first unheld edge.
  assign flushApply = !bus.ex_hold && (bus.ex_flush || pendingFlush_reg);
  assign stallEvent = hazard && !bus.ex_hold && !bus.ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      exValid_reg      <= 1'b0;
      exPc_reg         <= '0;
      exRs1_reg        <= '0;
      exRs2_reg        <= '0;
      exRd_reg         <= '0;
      exImm_reg        <= '0;
      exCtrl_reg       <= CTRL_NOP;
      exRs1Data_reg    <= '0;
      exRs2Data_reg    <= '0;
      exFwdA_reg       <= FWD_NONE;
      exFwdB_reg       <= FWD_NONE;
      pendingFlush_reg <= 1'b0;
    end else if (bus.ex_hold) begin
      if (bus.ex_flush) begin
        pendingFlush_reg <= 1'b1;
      end
    end else if (bus.ex_flush || pendingFlush_reg) begin
      exValid_reg      <= 1'b0;
      exCtrl_reg       <= CTRL_NOP;
      pendingFlush_reg <= 1'b0;
    end else if (hazard) begin
      exValid_reg <= 1'b0;
      exCtrl_reg  <= CTRL_NOP;
    end else begin
      exValid_reg   <= bus.id_valid;
      exPc_reg      <= bus.id_pc;
      exRs1_reg     <= bus.id_rs1;
      exRs2_reg     <= bus.id_rs2;
      exRd_reg      <= bus.id_rd;
      exImm_reg     <= bus.id_imm;
      exCtrl_reg    <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      exRs1Data_reg <= bus.readData1;
      exRs2Data_reg <= bus.readData2;
      exFwdA_reg    <= fwdA;
      exFwdB_reg    <= fwdB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount_reg <= '0;
      flushCount_reg <= '0;
    end else begin
      if (stallEvent && stallCount_reg != '1) begin
        stallCount_reg <= stallCount_reg + CNT_W'(1);
      end
      if (flushApply && flushCount_reg != '1) begin
        flushCount_reg <= flushCount_reg + CNT_W'(1);
      end
    end
  end

  assign bus.ifid_stall  = hazard || bus.ex_hold;
  assign bus.ex_valid    = exValid_reg;
  assign bus.ex_pc       = exPc_reg;
  assign bus.ex_rs1      = exRs1_reg;
  assign bus.ex_rs2      = exRs2_reg;
  assign bus.ex_rd       = exRd_reg;
  assign bus.ex_imm      = exImm_reg;
  assign bus.ex_ctrl     = exCtrl_reg;
  assign bus.ex_rs1Data  = exRs1Data_reg;
  assign bus.ex_rs2Data  = exRs2Data_reg;
  assign bus.ex_fwdA     = exFwdA_reg;
  assign bus.ex_fwdB     = exFwdB_reg;
  assign bus.stall_count = stallCount_reg;
  assign bus.flush_count = flushCount_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a full-width DUT and a 3-bit-counter DUT share stimulus.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 32;
  localparam int SMALL_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W))   bus ();
  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(SMALL_W)) busSmall ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W))   dut      (.clk(clk), .reset(reset), .bus(bus));
  id_ex_stage #(.XLEN(XLEN), .CNT_W(SMALL_W)) dutSmall (.clk(clk), .reset(reset), .bus(busSmall));

  typedef struct {
    logic rst, hold, flush;
    logic valid;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0] rs1, rs2, rd, mRd;
    logic useRs1, useRs2, mRegWrite;
    ctrl_t ctrl;
  } stim_t;

  typedef struct {
    logic valid;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0] rs1, rs2, rd;
    ctrl_t ctrl;
    fwd_sel_t fa, fb;
    logic pending;
    longint stallEv, flushEv;
  } model_t;

  typedef struct {
    model_t m;
    logic ifid;
  } exp_t;

  exp_t   expQ[$];
  model_t mdl;
  bit     primed = 0;
  int     checks = 0;
  int     failures = 0;
  int     txn = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.hold = 0; s.flush = 0; s.valid = 0;
    s.pc = 0; s.imm = 0; s.d1 = 0; s.d2 = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.mRd = 0;
    s.useRs1 = 0; s.useRs2 = 0; s.mRegWrite = 0;
    s.ctrl = CTRL_NOP;
    return s;
  endfunction

  function automatic model_t zeroModel();
    model_t m;
    m.valid = 0; m.pc = 0; m.imm = 0; m.d1 = 0; m.d2 = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.ctrl = CTRL_NOP;
    m.fa = FWD_NONE; m.fb = FWD_NONE; m.pending = 0;
    m.stallEv = 0; m.flushEv = 0;
    return m;
  endfunction

  // Is the register the ID instruction needs produced by a load now in EX?
  function automatic bit loadUse(model_t m, stim_t s);
    bit needs;
    if (!s.valid || !m.valid || !m.ctrl.memRead || m.rd == 0) return 0;
    needs = (s.useRs1 && s.rs1 == m.rd) || (s.useRs2 && s.rs2 == m.rd);
    return needs;
  endfunction

  function automatic fwd_sel_t modelFwd(model_t m, stim_t s, logic [4:0] rs, logic needed);
    if (!needed || rs == 0) return FWD_NONE;
    if (m.valid && m.ctrl.regWrite && m.rd == rs) return FWD_MEM;
    if (s.mRegWrite && s.mRd == rs) return FWD_WB;
    return FWD_NONE;
  endfunction

  function automatic model_t step(model_t m, stim_t s, bit hz);
    model_t n;
    n = m;
    if (s.rst) return zeroModel();
    if (hz && !s.hold && !s.flush) n.stallEv++;
    if (s.hold) begin
      if (s.flush) n.pending = 1;
    end else if (s.flush || m.pending) begin
      n.valid = 0; n.ctrl = CTRL_NOP; n.pending = 0; n.flushEv++;
    end else if (hz) begin
      n.valid = 0; n.ctrl = CTRL_NOP;
    end else begin
      n.valid = s.valid; n.pc = s.pc; n.imm = s.imm; n.d1 = s.d1; n.d2 = s.d2;
      n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
      n.ctrl = s.valid ? s.ctrl : CTRL_NOP;
      n.fa = modelFwd(m, s, s.rs1, s.useRs1);
      n.fb = modelFwd(m, s, s.rs2, s.useRs2);
    end
    return n;
  endfunction

  function automatic longint sat(longint v, int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst;
    bus.id_valid = s.valid;        busSmall.id_valid = s.valid;
    bus.id_pc = s.pc;              busSmall.id_pc = s.pc;
    bus.id_rs1 = s.rs1;            busSmall.id_rs1 = s.rs1;
    bus.id_rs2 = s.rs2;            busSmall.id_rs2 = s.rs2;
    bus.id_rd = s.rd;              busSmall.id_rd = s.rd;
    bus.id_useRs1 = s.useRs1;      busSmall.id_useRs1 = s.useRs1;
    bus.id_useRs2 = s.useRs2;      busSmall.id_useRs2 = s.useRs2;
    bus.id_imm = s.imm;            busSmall.id_imm = s.imm;
    bus.id_ctrl = s.ctrl;          busSmall.id_ctrl = s.ctrl;
    bus.readData1 = s.d1;          busSmall.readData1 = s.d1;
    bus.readData2 = s.d2;          busSmall.readData2 = s.d2;
    bus.exmem_rd = s.mRd;          busSmall.exmem_rd = s.mRd;
    bus.exmem_regWrite = s.mRegWrite; busSmall.exmem_regWrite = s.mRegWrite;
    bus.ex_flush = s.flush;        busSmall.ex_flush = s.flush;
    bus.ex_hold = s.hold;          busSmall.ex_hold = s.hold;
  endtask

  // One clock of stimulus: the entry pushed describes what the DUT must show before this edge.
  task automatic issue(input stim_t s);
    exp_t e;
    bit hz;
    drive(s);
    hz = primed ? loadUse(mdl, s) : 0;
    if (primed) begin
      e.m = mdl;
      e.ifid = hz || s.hold;
      expQ.push_back(e);
    end
    mdl = step(mdl, s, hz);
    if (s.rst) primed = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", name, txn, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        $display("txn %0d: ex_valid=%0b pc=%h ctrl=%h ifid_stall=%0b stall=%0d flush=%0d",
                 txn, bus.ex_valid, bus.ex_pc, bus.ex_ctrl, bus.ifid_stall,
                 bus.stall_count, bus.flush_count);
        check("ex_valid",    64'(bus.ex_valid),    64'(e.m.valid));
        check("ex_ctrl",     64'(bus.ex_ctrl),     64'(e.m.ctrl));
        check("ifid_stall",  64'(bus.ifid_stall),  64'(e.ifid));
        check("stall_count", 64'(bus.stall_count), 64'(sat(e.m.stallEv, CNT_W)));
        check("flush_count", 64'(bus.flush_count), 64'(sat(e.m.flushEv, CNT_W)));
        check("small_stall_count", 64'(busSmall.stall_count), 64'(sat(e.m.stallEv, SMALL_W)));
        check("small_flush_count", 64'(busSmall.flush_count), 64'(sat(e.m.flushEv, SMALL_W)));
        check("small_ex_valid", 64'(busSmall.ex_valid), 64'(e.m.valid));
        if (e.m.valid) begin
          check("ex_pc",      64'(bus.ex_pc),      64'(e.m.pc));
          check("ex_rs1",     64'(bus.ex_rs1),     64'(e.m.rs1));
          check("ex_rs2",     64'(bus.ex_rs2),     64'(e.m.rs2));
          check("ex_rd",      64'(bus.ex_rd),      64'(e.m.rd));
          check("ex_imm",     64'(bus.ex_imm),     64'(e.m.imm));
          check("ex_rs1Data", 64'(bus.ex_rs1Data), 64'(e.m.d1));
          check("ex_rs2Data", 64'(bus.ex_rs2Data), 64'(e.m.d2));
          check("ex_fwdA",    64'(bus.ex_fwdA),    64'(e.m.fa));
          check("ex_fwdB",    64'(bus.ex_fwdB),    64'(e.m.fb));
        end
        txn++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d entries outstanding", expQ.size());
    $fatal(1, "watchdog");
  end

  function automatic stim_t instr(input logic [31:0] pc, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input bit isLoad);
    stim_t s;
    s = idle();
    s.valid = 1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.useRs1 = 1; s.useRs2 = !isLoad;
    s.imm = pc ^ 32'h0000_0F0F; s.d1 = {pc[15:0], 16'hA5A5}; s.d2 = ~pc;
    s.ctrl.regWrite = 1;
    s.ctrl.memRead = isLoad;
    s.ctrl.memToReg = isLoad;
    s.ctrl.aluSrc = isLoad;
    s.ctrl.aluOp = isLoad ? 4'h0 : 4'h1;
    return s;
  endfunction

  initial begin : stimulus
    stim_t s;
    mdl = zeroModel();

    s = idle(); s.rst = 1;
    issue(s); issue(s);
    issue(idle());

    // First capture after reset.
    s = idle(); s.valid = 1; s.pc = 32'h100; s.rs1 = 5; s.useRs1 = 1; s.d1 = 32'hDEADBEEF;
    s.ctrl.regWrite = 1;
    issue(s);
    issue(idle());

    // lw x7 then add x9,x7,x2: one bubble, then WB forward once the load is in MEM.
    issue(instr(32'h200, 7, 1, 0, 1));
    issue(instr(32'h204, 9, 7, 2, 0));
    s = instr(32'h204, 9, 7, 2, 0); s.mRd = 7; s.mRegWrite = 1;
    issue(s);
    issue(idle());

    // add x3 then sub x4,x1,x3: MEM forward on B.
    issue(instr(32'h300, 3, 1, 2, 0));
    issue(instr(32'h304, 4, 1, 3, 0));
    // Load into x0: neither stall nor forward.
    issue(instr(32'h308, 0, 1, 0, 1));
    issue(instr(32'h30C, 4, 1, 0, 0));
    issue(idle());

    // Hold with flush for two cycles, then release.
    issue(instr(32'h400, 5, 1, 2, 0));
    s = instr(32'h404, 6, 1, 2, 0); s.hold = 1; s.flush = 1;
    issue(s); issue(s);
    issue(instr(32'h408, 6, 1, 2, 0));
    issue(idle());

    // Hazard and flush together.
    issue(instr(32'h500, 7, 1, 0, 1));
    s = instr(32'h504, 9, 7, 2, 0); s.flush = 1;
    issue(s);
    issue(idle());

    // Repeated load-use pairs drive the narrow counter into saturation.
    for (int i = 0; i < 10; i++) begin
      issue(instr(32'h600 + 32'(i * 8), 7, 1, 0, 1));
      issue(instr(32'h604 + 32'(i * 8), 9, 7, 2, 0));
    end
    issue(idle());

    // Reset while held with a pending flush.
    issue(instr(32'h700, 5, 1, 2, 0));
    s = idle(); s.hold = 1; s.flush = 1;
    issue(s);
    s.rst = 1;
    issue(s);
    issue(instr(32'h704, 5, 1, 2, 0));
    issue(idle());

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.valid = ($urandom_range(0, 9) != 0);
      s.pc = $urandom(); s.imm = $urandom(); s.d1 = $urandom(); s.d2 = $urandom();
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3)); s.mRd = 5'($urandom_range(0, 3));
      s.useRs1 = $urandom_range(0, 3) != 0; s.useRs2 = $urandom_range(0, 1) != 0;
      s.mRegWrite = $urandom_range(0, 1) != 0;
      s.ctrl = ctrl_t'(11'($urandom()));
      s.flush = ($urandom_range(0, 7) == 0);
      s.hold = ($urandom_range(0, 5) == 0);
      s.rst = ($urandom_range(0, 149) == 0);
      issue(s);
    end
    issue(idle());

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
